// File: rtl/regfile_wb_arbiter_if.sv
// Purpose: bundles the ALU/LSU writeback handshakes, the issue-stage hazard query and the array write port.
// Latency: none; wiring only.
// Backpressure: alu_ready/lsu_ready carry the arbiter's grants; WB_BYPASS_EN adds the forwarding outputs.
interface regfile_wb_arbiter_if;
    // ALU writeback request
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;

    // LSU load-data writeback request
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;

    // Issue stage: load dispatch and source operands
    logic        iss_load;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;
    logic [31:0] busy_vec;

    // Register array write port
    logic        wer;
    logic [4:0]  rd;
    logic [31:0] register_data;

`ifdef WB_BYPASS_EN
    // Bypass of the pending registered write
    logic        rs1_fwd;
    logic        rs2_fwd;
    logic [31:0] fwd_data;
`endif

    // Execute units, issue stage and array side
    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        output iss_load, iss_rd, rs1, rs2,
        input  hazard, busy_vec,
`ifdef WB_BYPASS_EN
        input  rs1_fwd, rs2_fwd, fwd_data,
`endif
        input  wer, rd, register_data
    );

    // Writeback arbiter side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        input  iss_load, iss_rd, rs1, rs2,
        output hazard, busy_vec,
`ifdef WB_BYPASS_EN
        output rs1_fwd, rs2_fwd, fwd_data,
`endif
        output wer, rd, register_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Purpose: arbitrates ALU/LSU writeback onto the 32x32 register array port and tracks in-flight loads (optional WB_BYPASS_EN forwarding).
// Latency: accept to wer is 1 cycle; ready and hazard are combinational.
// Backpressure: LSU has priority; an ALU refused MAX_WAIT cycles in a row wins one grant, and the loser holds its request.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    logic             alu_prio;
    logic             alu_rdy;
    logic             lsu_rdy;
    logic             alu_xfer;
    logic             lsu_xfer;
    logic [4:0]       gnt_rd;
    logic [31:0]      gnt_data;

    logic             wer_q;
    logic [4:0]       rd_q;
    logic [31:0]      data_q;

    logic [31:0]      busy_q;
    logic [31:0]      busy_nxt;

    logic             pend1;
    logic             pend2;
    logic             busy_hit;
    logic             hazard_c;

    // ALU takes priority once it has waited MAX_WAIT consecutive cycles
    assign alu_prio = (wait_cnt == WAIT_LIMIT);

    // Grant selection: one ready at most per cycle
    always_comb begin
        alu_rdy = 1'b0;
        lsu_rdy = 1'b0;
        if (alu_prio) begin
            alu_rdy = bus.alu_valid;
            lsu_rdy = bus.lsu_valid & ~bus.alu_valid;
        end else begin
            lsu_rdy = bus.lsu_valid;
            alu_rdy = bus.alu_valid & ~bus.lsu_valid;
        end
    end

    assign alu_xfer = bus.alu_valid & alu_rdy;
    assign lsu_xfer = bus.lsu_valid & lsu_rdy;

    // Mux the granted request onto the write stage input
    always_comb begin
        gnt_rd   = 5'd0;
        gnt_data = 32'd0;
        if (alu_xfer) begin
            gnt_rd   = bus.alu_rd;
            gnt_data = bus.alu_data;
        end else if (lsu_xfer) begin
            gnt_rd   = bus.lsu_rd;
            gnt_data = bus.lsu_data;
        end
    end

    // Registered write stage; x0 writes are accepted but never enable the array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wer_q  <= 1'b0;
            rd_q   <= 5'd0;
            data_q <= 32'd0;
        end else if (alu_xfer || lsu_xfer) begin
            wer_q  <= (gnt_rd != 5'd0);
            rd_q   <= gnt_rd;
            data_q <= gnt_data;
        end else begin
            wer_q  <= 1'b0;
        end
    end

    // Count consecutive ALU refusals, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!bus.alu_valid || alu_xfer) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Scoreboard update: clear on load return, then set on load issue so set wins
    always_comb begin
        busy_nxt = busy_q;
        if (lsu_xfer) begin
            busy_nxt[bus.lsu_rd] = 1'b0;
        end
        if (bus.iss_load && (bus.iss_rd != 5'd0)) begin
            busy_nxt[bus.iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // RAW detection against in-flight loads and the not-yet-landed registered write
    always_comb begin
        pend1    = wer_q & (rd_q == bus.rs1) & (bus.rs1 != 5'd0);
        pend2    = wer_q & (rd_q == bus.rs2) & (bus.rs2 != 5'd0);
        busy_hit = (busy_q[bus.rs1] & (bus.rs1 != 5'd0)) |
                   (busy_q[bus.rs2] & (bus.rs2 != 5'd0));
`ifdef WB_BYPASS_EN
        hazard_c = busy_hit;
`else
        hazard_c = busy_hit | pend1 | pend2;
`endif
    end

    assign bus.alu_ready     = alu_rdy;
    assign bus.lsu_ready     = lsu_rdy;
    assign bus.hazard        = hazard_c;
    assign bus.busy_vec      = busy_q;
    assign bus.wer           = wer_q;
    assign bus.rd            = rd_q;
    assign bus.register_data = data_q;

`ifdef WB_BYPASS_EN
    assign bus.rs1_fwd  = pend1;
    assign bus.rs2_fwd  = pend2;
    assign bus.fwd_data = data_q;
`endif

endmodule
